// File: rtl/mdu_pkg.sv
// Shared encodings and types for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   localparam logic [3:0] ALU_OP_MULTU = 4'd3;
   localparam logic [3:0] ALU_OP_DIVU  = 4'd4;

   typedef enum logic {
      IDLE,
      RUN
   } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [3:0]         i_op,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   output logic [2*WIDTH-1:0] o_acc,
   output logic               o_qbit
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_diff;
   logic           w_ge;

   assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
   assign w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
   assign w_diff   = w_rem_sh - {1'b0, i_opnd};
   assign w_ge     = (w_rem_sh >= {1'b0, i_opnd});

   // Divide leaves the low bit clear; the quotient bit is returned apart.
   always_comb begin
      o_acc  = '0;
      o_qbit = 1'b0;
      if (i_op == ALU_OP_DIVU) begin
         o_qbit = w_ge;
         o_acc  = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                   i_acc[WIDTH-2:0], 1'b0};
      end else if (i_acc[0]) begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
         o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mdu_hilo.sv
// MULTU/DIVU unit with HI/LO registers and EX-stage stall request.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             mf_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall_req
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   mdu_state_t         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_opnd;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic [2*WIDTH-1:0] w_step;
   logic               w_qbit;
   logic [2*WIDTH-1:0] w_acc_nx;
   logic               w_valid;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .i_op   (r_op),
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .o_acc  (w_step),
      .o_qbit (w_qbit)
   );

   assign w_acc_nx = {w_step[2*WIDTH-1:1], w_step[0] | w_qbit};
   assign w_valid  = (alu_op == ALU_OP_MULTU) || (alu_op == ALU_OP_DIVU);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_opnd  <= '0;
         r_acc   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && w_valid) begin
                  r_op    <= alu_op;
                  r_cnt   <= '0;
                  r_state <= RUN;
                  // Divide shifts the dividend in; multiply shifts the multiplier out.
                  if (alu_op == ALU_OP_DIVU) begin
                     r_opnd <= rt_data;
                     r_acc  <= {{WIDTH{1'b0}}, rs_data};
                  end else begin
                     r_opnd <= rs_data;
                     r_acc  <= {{WIDTH{1'b0}}, rt_data};
                  end
               end
            end
            RUN: begin
               r_acc <= w_acc_nx;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) begin
                  r_hi    <= w_acc_nx[2*WIDTH-1:WIDTH];
                  r_lo    <= w_acc_nx[WIDTH-1:0];
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign hi        = r_hi;
   assign lo        = r_lo;
   assign busy      = (r_state == RUN);
   assign done      = r_done;
   assign stall_req = busy & (start | mf_req);

endmodule
